axis_upsize_rr_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one AXI-stream upsizer between NUM_SRC narrow requester streams. It picks one source, locks the grant until that source's packet ends or its fairness quota runs out, and forwards beats unmodified to the upsizer input. The quota is counted in whole NUM_REG-beat groups, so a grant never changes in the middle of an upsized word. A source ID travels with the data so downstream logic can route the wide words.

---
 rtl/axis_upsize_rr_arbiter_pkg.sv | 18 +
 rtl/axis_upsize_rr_arbiter_if.sv | 31 +++
 rtl/axis_upsize_rr_arbiter_rr_pick.sv | 40 ++++
 rtl/axis_upsize_rr_arbiter.sv | 117 +++++++++++
 tb/tb_axis_upsize_rr_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_upsize_rr_arbiter_pkg.sv
// Shared types and helpers for the packet-level round-robin arbiter in front of the
// AXI-stream upsizer.
package axis_arb_pkg;

  localparam int unsigned WIDTH_DEF   = 32;
  localparam int unsigned NUM_REG_DEF = 2;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } state_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_upsize_rr_arbiter_if.sv
// AXI-stream bundle carrying N parallel lanes; the arbiter uses N=NUM_SRC on the
// requester side and N=1 on the upsizer side.
interface axis_upsize_rr_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 1,
  parameter int unsigned IDW   = 1
) ();

  logic [N-1:0]       tvalid;
  logic [N-1:0]       tready;
  logic [N*WIDTH-1:0] tdata;
  logic [N-1:0]       tlast;
  logic [IDW-1:0]     tid;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    output tid,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    input  tid,
    output tready
  );

endinterface

// File: rtl/axis_upsize_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester strictly after `last`,
// wrapping around, wins.
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned IDW     = clog2_min1(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDW-1:0]     last,
  output logic [IDW-1:0]     idx,
  output logic               any
);

  logic [NUM_SRC-1:0] rot;
  logic [IDW-1:0]     pos;
  logic [IDW-1:0]     off;
  logic               found;

  always_comb begin
    rot   = '0;
    pos   = '0;
    off   = '0;
    found = 1'b0;
    // Rotate so that bit 0 is the source just after the last winner.
    for (int k = 0; k < NUM_SRC; k++) begin
      pos    = IDW'((int'(last) + 1 + k) % NUM_SRC);
      rot[k] = req[pos];
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      if (rot[k] && !found) begin
        off   = IDW'(k);
        found = 1'b1;
      end
    end
    any = found;
    idx = IDW'((int'(last) + 1 + int'(off)) % NUM_SRC);
  end

endmodule

// File: rtl/axis_upsize_rr_arbiter.sv
// Packet-level round-robin arbiter feeding one upsizer; a grant is held until tlast
// or until the per-grant quota of NUM_REG-beat groups is used up.
module axis_upsize_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned NUM_REG    = NUM_REG_DEF,
  parameter int unsigned MAX_GROUPS = 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  axis_upsize_rr_arbiter_if.slave   s_axis,
  axis_upsize_rr_arbiter_if.master  m_axis,
  output logic                      busy
);

  localparam int unsigned IDW = clog2_min1(NUM_SRC);
  localparam int unsigned BCW = clog2_min1(NUM_REG);
  localparam int unsigned GCW = clog2_min1(MAX_GROUPS);

  localparam logic [BCW-1:0] BeatLast = BCW'(NUM_REG - 1);
  localparam logic [GCW-1:0] GrpLast  = GCW'(MAX_GROUPS - 1);
  localparam bit             QuotaEn  = (MAX_GROUPS != 0);

  state_e         state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
  logic [GCW-1:0] grp_cnt_q, grp_cnt_d;

  logic [IDW-1:0] pick_idx;
  logic           pick_any;
  logic           fwd_valid;
  logic           hs;
  logic           grp_done;

  logic [WIDTH-1:0] src_data [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src_data
    assign src_data[i] = s_axis.tdata[i*WIDTH +: WIDTH];
  end

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDW     (IDW)
  ) u_rr_pick (
    .req  (s_axis.tvalid),
    .last (last_grant_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    grp_cnt_d    = grp_cnt_q;
    fwd_valid    = 1'b0;
    hs           = 1'b0;
    grp_done     = 1'b0;
    busy         = 1'b0;

    s_axis.tready = '0;
    m_axis.tdata  = src_data[grant_q];
    m_axis.tlast  = s_axis.tlast[grant_q];
    m_axis.tid    = grant_q;

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = StGrant;
        end
      end
      StGrant: begin
        busy                   = 1'b1;
        fwd_valid              = s_axis.tvalid[grant_q];
        s_axis.tready[grant_q] = m_axis.tready;
        hs                     = fwd_valid && m_axis.tready;
        if (hs) begin
          grp_done   = (beat_cnt_q == BeatLast);
          beat_cnt_d = grp_done ? '0 : beat_cnt_q + 1'b1;
          grp_cnt_d  = grp_done ? grp_cnt_q + 1'b1 : grp_cnt_q;
          // Quota release only lands on a group boundary, so no wide word is split.
          if (s_axis.tlast[grant_q] || (QuotaEn && grp_done && (grp_cnt_q == GrpLast))) begin
            beat_cnt_d   = '0;
            grp_cnt_d    = '0;
            last_grant_d = grant_q;
            state_d      = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    m_axis.tvalid = fwd_valid;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= IDW'(NUM_SRC - 1);
      beat_cnt_q   <= '0;
      grp_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      grp_cnt_q    <= grp_cnt_d;
    end
  end

endmodule

// File: tb/tb_axis_upsize_rr_arbiter.sv
// Directed bench for the round-robin upsizer arbiter: a packet-level model is checked
// every cycle and hand-written beat sequences pin the model down.
module tb_axis_upsize_rr_arbiter;

  localparam int NS = 4;
  localparam int W  = 32;
  localparam int NR = 2;
  localparam int MG = 2;
  localparam int IW = 2;
  localparam int TO = 400;

  logic aclk = 1'b0;
  logic aresetn;
  logic busy;

  always #5 aclk = ~aclk;

  axis_upsize_rr_arbiter_if #(.WIDTH(W), .N(NS), .IDW(IW)) s_if ();
  axis_upsize_rr_arbiter_if #(.WIDTH(W), .N(1), .IDW(IW)) m_if ();

  axis_upsize_rr_arbiter #(
    .WIDTH      (W),
    .NUM_SRC    (NS),
    .NUM_REG    (NR),
    .MAX_GROUPS (MG)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axis  (s_if),
    .m_axis  (m_if),
    .busy    (busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Source packet queues and the values currently driven
  logic [31:0] qd[NS][$];
  bit          ql[NS][$];
  logic [NS-1:0]   src_valid = '0;
  logic [NS-1:0]   src_last  = '0;
  logic [NS*W-1:0] src_data  = '0;
  logic            mready    = 1'b1;

  // Packet-level model
  bit mdl_busy  = 1'b0;
  int mdl_grant = 0;
  int mdl_last  = NS - 1;
  int mdl_beats = 0;
  bit hs_src[NS];
  bit cmp_en = 1'b0;
  int cyc = 0;

  int          out_tid[$];
  logic [31:0] out_data[$];
  int          out_cyc[$];

  always @(negedge aclk) begin : compare
    logic [NS-1:0] exp_ready;
    int g;
    bit found;
    cyc++;
    foreach (hs_src[i]) hs_src[i] = 1'b0;
    if (cmp_en) begin
      g = mdl_grant;
      exp_ready = '0;
      if (mdl_busy) exp_ready[g] = mready;
      chk("m_tvalid", m_if.tvalid, mdl_busy ? src_valid[g] : 1'b0);
      chk("s_tready", s_if.tready, exp_ready);
      chk("busy", busy, mdl_busy);
      if (mdl_busy) chk("m_tid", m_if.tid, g);
      if (mdl_busy && src_valid[g]) begin
        chk("m_tdata", m_if.tdata, src_data[g*W +: W]);
        chk("m_tlast", m_if.tlast, src_last[g]);
      end
      if (m_if.tvalid === 1'b1 && mready) begin
        out_tid.push_back(int'(m_if.tid));
        out_data.push_back(m_if.tdata);
        out_cyc.push_back(cyc);
      end
      if (!aresetn) begin
        mdl_busy  = 1'b0;
        mdl_grant = 0;
        mdl_last  = NS - 1;
        mdl_beats = 0;
      end else if (!mdl_busy) begin
        found = 1'b0;
        for (int k = 1; k <= NS; k++) begin
          if (!found && src_valid[(mdl_last + k) % NS]) begin
            found     = 1'b1;
            mdl_grant = (mdl_last + k) % NS;
          end
        end
        if (found) begin
          mdl_busy  = 1'b1;
          mdl_beats = 0;
        end
      end else if (src_valid[g] && mready) begin
        hs_src[g] = 1'b1;
        mdl_beats++;
        if (src_last[g] || (MG != 0 && mdl_beats == NR * MG)) begin
          mdl_busy  = 1'b0;
          mdl_last  = g;
          mdl_beats = 0;
        end
      end
    end
  end

  task automatic drive(input bit rdy);
    mready = rdy;
    for (int i = 0; i < NS; i++) begin
      if (qd[i].size() > 0) begin
        src_valid[i]          = 1'b1;
        src_data[i*W +: W]    = qd[i][0];
        src_last[i]           = ql[i][0];
      end else begin
        src_valid[i]          = 1'b0;
        src_data[i*W +: W]    = '0;
        src_last[i]           = 1'b0;
      end
    end
    s_if.tvalid = src_valid;
    s_if.tdata  = src_data;
    s_if.tlast  = src_last;
    m_if.tready = rdy;
  endtask

  task automatic pop();
    for (int i = 0; i < NS; i++) begin
      if (hs_src[i] && qd[i].size() > 0) begin
        void'(qd[i].pop_front());
        void'(ql[i].pop_front());
      end
    end
  endtask

  task automatic cycle(input bit rdy);
    @(posedge aclk);
    #1;
    pop();
    drive(rdy);
  endtask

  task automatic push_pkt(input int src, input logic [31:0] base, input int n);
    for (int b = 0; b < n; b++) begin
      qd[src].push_back(base + 32'(b));
      ql[src].push_back(b == n - 1);
    end
  endtask

  task automatic clear_log();
    out_tid.delete();
    out_data.delete();
    out_cyc.delete();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NS; i++) if (qd[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string nm);
    int n = 0;
    while ((!all_empty() || mdl_busy) && n < TO) begin
      cycle(1'b1);
      n++;
    end
    chk({nm, "_drain_done"}, n < TO, 1'b1);
  endtask

  task automatic check_log(input string nm, input int et[$], input logic [31:0] ed[$]);
    chk({nm, "_len"}, out_tid.size(), et.size());
    foreach (et[k]) begin
      if (k < out_tid.size()) begin
        chk($sformatf("%s_tid%0d", nm, k), out_tid[k], et[k]);
        chk($sformatf("%s_data%0d", nm, k), out_data[k], ed[k]);
      end
    end
  endtask

  task automatic check_gap(input string nm, input int a, input int b, input int exp);
    if (a < out_cyc.size() && b < out_cyc.size()) chk(nm, out_cyc[b] - out_cyc[a], exp);
    else chk(nm, 64'hdead, exp);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int et[$];
    logic [31:0] ed[$];

    aresetn   = 1'b0;
    s_if.tid  = '0;
    drive(1'b1);
    repeat (2) @(posedge aclk);
    #1;
    cmp_en = 1'b1;
    @(negedge aclk);
    #1;
    chk("rst_tvalid", m_if.tvalid, 1'b0);
    chk("rst_tready", s_if.tready, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tid", m_if.tid, 2'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    pop();
    drive(1'b1);

    // Single source, one bubble then four back-to-back beats
    clear_log();
    push_pkt(0, 32'hA0, 4);
    cycle(1'b1);
    @(negedge aclk);
    #1;
    chk("t1_bubble_tvalid", m_if.tvalid, 1'b0);
    chk("t1_bubble_busy", busy, 1'b0);
    cycle(1'b1);
    @(negedge aclk);
    #1;
    chk("t1_first_tvalid", m_if.tvalid, 1'b1);
    chk("t1_first_data", m_if.tdata, 32'hA0);
    drain("t1");
    @(negedge aclk);
    #1;
    chk("t1_busy_after", busy, 1'b0);
    et = '{0, 0, 0, 0};
    ed = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    check_log("t1", et, ed);
    check_gap("t1_consecutive", 0, 3, 3);

    // Odd-length packet clears counters: the following 6-beat packet gets a full quota
    clear_log();
    push_pkt(3, 32'h30, 3);
    push_pkt(3, 32'h40, 6);
    drain("t5");
    et = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
    ed = '{32'h30, 32'h31, 32'h32, 32'h40, 32'h41, 32'h42, 32'h43, 32'h44, 32'h45};
    check_log("t5", et, ed);
    check_gap("t5_after_short", 2, 3, 2);
    check_gap("t5_quota_run", 3, 6, 3);
    check_gap("t5_quota_break", 6, 7, 2);

    // All four sources with 2-beat packets: order 0,1,2,3,0
    clear_log();
    for (int s = 0; s < NS; s++) push_pkt(s, 32'h100 * s, 2);
    push_pkt(0, 32'h010, 2);
    drain("t2");
    et = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    ed = '{32'h000, 32'h001, 32'h100, 32'h101, 32'h200, 32'h201,
           32'h300, 32'h301, 32'h010, 32'h011};
    check_log("t2", et, ed);
    check_gap("t2_bubble", 1, 2, 2);

    // Quota: src1 long packet yields to waiting src2 after 4 beats, then resumes
    clear_log();
    push_pkt(1, 32'h50, 10);
    cycle(1'b1);
    push_pkt(2, 32'h60, 2);
    drain("t3");
    et = '{1, 1, 1, 1, 2, 2, 1, 1, 1, 1, 1, 1};
    ed = '{32'h50, 32'h51, 32'h52, 32'h53, 32'h60, 32'h61,
           32'h54, 32'h55, 32'h56, 32'h57, 32'h58, 32'h59};
    check_log("t3", et, ed);

    // Backpressure on the upsizer side
    clear_log();
    push_pkt(0, 32'h70, 3);
    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b0);
    cycle(1'b0);
    cycle(1'b1);
    cycle(1'b0);
    cycle(1'b1);
    drain("t4");
    et = '{0, 0, 0};
    ed = '{32'h70, 32'h71, 32'h72};
    check_log("t4", et, ed);
    check_gap("t4_stall1", 0, 1, 3);
    check_gap("t4_stall2", 1, 2, 2);

    // Reset during the second beat of a src2 packet
    push_pkt(2, 32'h80, 4);
    cycle(1'b1);
    cycle(1'b1);
    @(posedge aclk);
    #1;
    pop();
    aresetn = 1'b0;
    drive(1'b1);
    @(posedge aclk);
    #1;
    pop();
    aresetn = 1'b1;
    for (int s = 0; s < NS; s++) begin
      qd[s].delete();
      ql[s].delete();
    end
    for (int s = 0; s < NS; s++) push_pkt(s, 32'h90 + 32'h10 * s, 2);
    drive(1'b1);
    clear_log();
    @(negedge aclk);
    #1;
    chk("t6_rst_tvalid", m_if.tvalid, 1'b0);
    chk("t6_rst_tready", s_if.tready, 4'b0000);
    chk("t6_rst_busy", busy, 1'b0);
    drain("t6");
    et = '{0, 0, 1, 1, 2, 2, 3, 3};
    ed = '{32'h90, 32'h91, 32'hA0, 32'hA1, 32'hB0, 32'hB1, 32'hC0, 32'hC1};
    check_log("t6", et, ed);

    cycle(1'b1);
    cycle(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
